// File: rtl/id_ex_stage_reg_if.sv
// ID/EX bundle: decode-side id_* fields and the registered ex_* copies.
// master drives decode fields; slave is the pipeline register.
interface id_ex_stage_reg_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int ALUOP_W = 4
);
  logic               id_valid;
  logic [ADDR_W-1:0]  id_rs_addr;
  logic [ADDR_W-1:0]  id_rt_addr;
  logic [ADDR_W-1:0]  id_rd_addr;
  logic               id_uses_rt;
  logic [DATA_W-1:0]  id_rd_data1;
  logic [DATA_W-1:0]  id_rd_data2;
  logic [DATA_W-1:0]  id_imm;
  logic [DATA_W-1:0]  id_pc;
  logic               id_ctrl_reg_wr;
  logic               id_ctrl_mem_rd;
  logic               id_ctrl_mem_wr;
  logic               id_ctrl_mem_to_reg;
  logic               id_ctrl_alu_src;
  logic               id_ctrl_reg_dst;
  logic [ALUOP_W-1:0] id_ctrl_alu_op;

  logic               ex_valid;
  logic [ADDR_W-1:0]  ex_rs_addr;
  logic [ADDR_W-1:0]  ex_rt_addr;
  logic [ADDR_W-1:0]  ex_rd_addr;
  logic [DATA_W-1:0]  ex_rd_data1;
  logic [DATA_W-1:0]  ex_rd_data2;
  logic [DATA_W-1:0]  ex_imm;
  logic [DATA_W-1:0]  ex_pc;
  logic               ex_ctrl_reg_wr;
  logic               ex_ctrl_mem_rd;
  logic               ex_ctrl_mem_wr;
  logic               ex_ctrl_mem_to_reg;
  logic               ex_ctrl_alu_src;
  logic               ex_ctrl_reg_dst;
  logic [ALUOP_W-1:0] ex_ctrl_alu_op;

  modport master (
    output id_valid, id_rs_addr, id_rt_addr, id_rd_addr,
    output id_uses_rt, id_rd_data1, id_rd_data2, id_imm, id_pc,
    output id_ctrl_reg_wr, id_ctrl_mem_rd, id_ctrl_mem_wr,
    output id_ctrl_mem_to_reg, id_ctrl_alu_src, id_ctrl_reg_dst,
    output id_ctrl_alu_op,
    input  ex_valid, ex_rs_addr, ex_rt_addr, ex_rd_addr,
    input  ex_rd_data1, ex_rd_data2, ex_imm, ex_pc,
    input  ex_ctrl_reg_wr, ex_ctrl_mem_rd, ex_ctrl_mem_wr,
    input  ex_ctrl_mem_to_reg, ex_ctrl_alu_src, ex_ctrl_reg_dst,
    input  ex_ctrl_alu_op
  );

  modport slave (
    input  id_valid, id_rs_addr, id_rt_addr, id_rd_addr,
    input  id_uses_rt, id_rd_data1, id_rd_data2, id_imm, id_pc,
    input  id_ctrl_reg_wr, id_ctrl_mem_rd, id_ctrl_mem_wr,
    input  id_ctrl_mem_to_reg, id_ctrl_alu_src, id_ctrl_reg_dst,
    input  id_ctrl_alu_op,
    output ex_valid, ex_rs_addr, ex_rt_addr, ex_rd_addr,
    output ex_rd_data1, ex_rd_data2, ex_imm, ex_pc,
    output ex_ctrl_reg_wr, ex_ctrl_mem_rd, ex_ctrl_mem_wr,
    output ex_ctrl_mem_to_reg, ex_ctrl_alu_src, ex_ctrl_reg_dst,
    output ex_ctrl_alu_op
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection and stall counter.
// Optional ID_EX_WB_BYPASS_EN: forward same-cycle writeback into operands.
module id_ex_stage_reg #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int ALUOP_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  id_ex_stage_reg_if.slave  pipe,
  input  logic              ex_flush,
  input  logic              ex_hold,
  input  logic              wb_reg_wr,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              load_use_stall,
  output logic [7:0]        stall_count
);

  logic              rs_hit;
  logic              rt_hit;
  logic              ctl;
  logic [DATA_W-1:0] data1_nx;
  logic [DATA_W-1:0] data2_nx;

  assign rs_hit = pipe.ex_rt_addr == pipe.id_rs_addr;
  assign rt_hit = pipe.id_uses_rt
                & (pipe.ex_rt_addr == pipe.id_rt_addr);

  assign load_use_stall = pipe.id_valid & pipe.ex_valid
                        & pipe.ex_ctrl_mem_rd
                        & (pipe.ex_rt_addr != '0)
                        & (rs_hit | rt_hit)
                        & ~ex_flush & ~ex_hold;

  // Control of an invalid decode slot must never reach EX
  assign ctl = pipe.id_valid;

`ifdef ID_EX_WB_BYPASS_EN
  logic byp1;
  logic byp2;

  assign byp1 = wb_reg_wr & (wb_addr != '0)
              & (wb_addr == pipe.id_rs_addr);
  assign byp2 = wb_reg_wr & (wb_addr != '0)
              & (wb_addr == pipe.id_rt_addr);
  assign data1_nx = byp1 ? wb_data : pipe.id_rd_data1;
  assign data2_nx = byp2 ? wb_data : pipe.id_rd_data2;
`else
  logic unused_wb;

  assign unused_wb = ^{wb_reg_wr, wb_addr, wb_data};
  assign data1_nx  = pipe.id_rd_data1;
  assign data2_nx  = pipe.id_rd_data2;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset || ex_flush || (!ex_hold && load_use_stall)) begin
      pipe.ex_valid           <= 1'b0;
      pipe.ex_rs_addr         <= '0;
      pipe.ex_rt_addr         <= '0;
      pipe.ex_rd_addr         <= '0;
      pipe.ex_rd_data1        <= '0;
      pipe.ex_rd_data2        <= '0;
      pipe.ex_imm             <= '0;
      pipe.ex_pc              <= '0;
      pipe.ex_ctrl_reg_wr     <= 1'b0;
      pipe.ex_ctrl_mem_rd     <= 1'b0;
      pipe.ex_ctrl_mem_wr     <= 1'b0;
      pipe.ex_ctrl_mem_to_reg <= 1'b0;
      pipe.ex_ctrl_alu_src    <= 1'b0;
      pipe.ex_ctrl_reg_dst    <= 1'b0;
      pipe.ex_ctrl_alu_op     <= '0;
    end else if (!ex_hold) begin
      pipe.ex_valid           <= pipe.id_valid;
      pipe.ex_rs_addr         <= pipe.id_rs_addr;
      pipe.ex_rt_addr         <= pipe.id_rt_addr;
      pipe.ex_rd_addr         <= pipe.id_rd_addr;
      pipe.ex_rd_data1        <= data1_nx;
      pipe.ex_rd_data2        <= data2_nx;
      pipe.ex_imm             <= pipe.id_imm;
      pipe.ex_pc              <= pipe.id_pc;
      pipe.ex_ctrl_reg_wr     <= ctl & pipe.id_ctrl_reg_wr;
      pipe.ex_ctrl_mem_rd     <= ctl & pipe.id_ctrl_mem_rd;
      pipe.ex_ctrl_mem_wr     <= ctl & pipe.id_ctrl_mem_wr;
      pipe.ex_ctrl_mem_to_reg <= ctl & pipe.id_ctrl_mem_to_reg;
      pipe.ex_ctrl_alu_src    <= ctl & pipe.id_ctrl_alu_src;
      pipe.ex_ctrl_reg_dst    <= ctl & pipe.id_ctrl_reg_dst;
      pipe.ex_ctrl_alu_op     <= ctl ? pipe.id_ctrl_alu_op : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_count <= 8'd0;
    else if (load_use_stall && stall_count != 8'hFF)
      stall_count <= stall_count + 8'd1;
  end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: reset, hazards, flush, hold, bypass.
module tb_id_ex_stage_reg;

  logic        clk;
  logic        reset;
  logic        ex_flush;
  logic        ex_hold;
  logic        wb_reg_wr;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        load_use_stall;
  logic [7:0]  stall_count;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  id_ex_stage_reg_if ifc ();

  id_ex_stage_reg dut (
    .clk            (clk),
    .reset          (reset),
    .pipe           (ifc.slave),
    .ex_flush       (ex_flush),
    .ex_hold        (ex_hold),
    .wb_reg_wr      (wb_reg_wr),
    .wb_addr        (wb_addr),
    .wb_data        (wb_data),
    .load_use_stall (load_use_stall),
    .stall_count    (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [4:0] rs,
                     input logic [4:0] rt, input logic urt,
                     input logic [31:0] d1, input logic mrd);
    ifc.id_valid           = v;
    ifc.id_rs_addr         = rs;
    ifc.id_rt_addr         = rt;
    ifc.id_rd_addr         = 5'd3;
    ifc.id_uses_rt         = urt;
    ifc.id_rd_data1        = d1;
    ifc.id_rd_data2        = ~d1;
    ifc.id_imm             = 32'h0000_0010;
    ifc.id_pc              = 32'h0000_0104;
    ifc.id_ctrl_reg_wr     = 1'b1;
    ifc.id_ctrl_mem_rd     = mrd;
    ifc.id_ctrl_mem_wr     = 1'b0;
    ifc.id_ctrl_mem_to_reg = mrd;
    ifc.id_ctrl_alu_src    = mrd;
    ifc.id_ctrl_reg_dst    = ~mrd;
    ifc.id_ctrl_alu_op     = 4'h2;
  endtask

  task automatic bump();
    if (exp_cnt < 255) exp_cnt++;
  endtask

  initial begin
    reset = 1'b0;
    ex_flush = 1'b0;
    ex_hold = 1'b0;
    wb_reg_wr = 1'b0;
    wb_addr = 5'd0;
    wb_data = 32'd0;
    for (int i = 0; i < 4; i++) begin
      put(1'b1, 5'($urandom), 5'($urandom), 1'b1,
          $urandom, 1'($urandom));
      tick();
    end
    chk("rst_valid", 32'(ifc.ex_valid), 32'd0);
    chk("rst_d1", ifc.ex_rd_data1, 32'd0);
    chk("rst_pc", ifc.ex_pc, 32'd0);
    chk("rst_memrd", 32'(ifc.ex_ctrl_mem_rd), 32'd0);
    chk("rst_alu_op", 32'(ifc.ex_ctrl_alu_op), 32'd0);
    chk("rst_cnt", 32'(stall_count), 32'd0);
    chk("rst_stall", 32'(load_use_stall), 32'd0);

    reset = 1'b1;
    put(1'b1, 5'd1, 5'd2, 1'b1, 32'h1234_5678, 1'b0);
    tick();
    chk("cap_d1", ifc.ex_rd_data1, 32'h1234_5678);
    chk("cap_d2", ifc.ex_rd_data2, 32'hEDCB_A987);
    chk("cap_valid", 32'(ifc.ex_valid), 32'd1);
    chk("cap_pc", ifc.ex_pc, 32'h0000_0104);

    // lw rt=5 followed by add rs=5
    put(1'b1, 5'd1, 5'd5, 1'b0, 32'h0000_0001, 1'b1);
    tick();
    chk("lw_memrd", 32'(ifc.ex_ctrl_mem_rd), 32'd1);
    put(1'b1, 5'd5, 5'd6, 1'b1, 32'h0000_0AAD, 1'b0);
    #1;
    chk("lu_stall", 32'(load_use_stall), 32'd1);
    bump();
    tick();
    chk("lu_bubble", 32'(ifc.ex_valid), 32'd0);
    chk("lu_bub_regwr", 32'(ifc.ex_ctrl_reg_wr), 32'd0);
    chk("lu_cnt", 32'(stall_count), 32'(exp_cnt));
    chk("lu_clear", 32'(load_use_stall), 32'd0);
    tick();
    chk("lu_after_v", 32'(ifc.ex_valid), 32'd1);
    chk("lu_after_rs", 32'(ifc.ex_rs_addr), 32'd5);
    chk("lu_after_d1", ifc.ex_rd_data1, 32'h0000_0AAD);

    // r0 load never hazards
    put(1'b1, 5'd1, 5'd0, 1'b0, 32'd0, 1'b1);
    tick();
    put(1'b1, 5'd0, 5'd0, 1'b1, 32'd0, 1'b0);
    #1;
    chk("r0_nostall", 32'(load_use_stall), 32'd0);

    // rt match without id_uses_rt
    put(1'b1, 5'd1, 5'd7, 1'b0, 32'd0, 1'b1);
    tick();
    put(1'b1, 5'd3, 5'd7, 1'b0, 32'd0, 1'b0);
    #1;
    chk("rt_nouse", 32'(load_use_stall), 32'd0);
    ifc.id_uses_rt = 1'b1;
    #1;
    chk("rt_use", 32'(load_use_stall), 32'd1);
    ex_flush = 1'b1;
    #1;
    chk("flush_stall", 32'(load_use_stall), 32'd0);
    tick();
    ex_flush = 1'b0;
    chk("flush_valid", 32'(ifc.ex_valid), 32'd0);
    chk("flush_memrd", 32'(ifc.ex_ctrl_mem_rd), 32'd0);
    chk("flush_cnt", 32'(stall_count), 32'(exp_cnt));

    // hold freezes ex_* for three edges
    put(1'b1, 5'd4, 5'd8, 1'b1, 32'h0000_AAAA, 1'b0);
    tick();
    chk("hold_pre", ifc.ex_rd_data1, 32'h0000_AAAA);
    ex_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      put(1'b1, 5'(i + 10), 5'd9, 1'b1, 32'(i), 1'b1);
      tick();
      chk("hold_d1", ifc.ex_rd_data1, 32'h0000_AAAA);
      chk("hold_rs", 32'(ifc.ex_rs_addr), 32'd4);
    end
    ex_hold = 1'b0;
    put(1'b1, 5'd11, 5'd12, 1'b1, 32'h0000_BBBB, 1'b0);
    tick();
    chk("hold_rel", ifc.ex_rd_data1, 32'h0000_BBBB);
    chk("hold_rel_rs", 32'(ifc.ex_rs_addr), 32'd11);

    // invalid decode slot forces control low
    put(1'b0, 5'd1, 5'd2, 1'b1, 32'h5, 1'b1);
    tick();
    chk("inv_valid", 32'(ifc.ex_valid), 32'd0);
    chk("inv_memrd", 32'(ifc.ex_ctrl_mem_rd), 32'd0);
    chk("inv_regwr", 32'(ifc.ex_ctrl_reg_wr), 32'd0);

    wb_reg_wr = 1'b1;
    wb_addr = 5'd9;
    wb_data = 32'hDEAD_BEEF;
    put(1'b1, 5'd9, 5'd2, 1'b1, 32'd0, 1'b0);
    tick();
`ifdef ID_EX_WB_BYPASS_EN
    chk("byp_d1", ifc.ex_rd_data1, 32'hDEAD_BEEF);
`else
    chk("byp_d1", ifc.ex_rd_data1, 32'd0);
`endif
    chk("byp_d2", ifc.ex_rd_data2, 32'hFFFF_FFFF);
    wb_addr = 5'd0;
    put(1'b1, 5'd0, 5'd2, 1'b1, 32'h77, 1'b0);
    tick();
    chk("byp_r0", ifc.ex_rd_data1, 32'h77);
    wb_reg_wr = 1'b0;

    // drive many load-use pairs to hit saturation
    for (int i = 0; i < 260; i++) begin
      put(1'b1, 5'd1, 5'd5, 1'b0, 32'd0, 1'b1);
      tick();
      put(1'b1, 5'd5, 5'd6, 1'b0, 32'd0, 1'b0);
      bump();
      tick();
      if (i == 250)
        chk("cnt_mid", 32'(stall_count), 32'(exp_cnt));
    end
    chk("cnt_sat", 32'(stall_count), 32'd255);
    chk("cnt_model", 32'(stall_count), 32'(exp_cnt));

    // reset during a stall
    put(1'b1, 5'd1, 5'd5, 1'b0, 32'd0, 1'b1);
    tick();
    put(1'b1, 5'd5, 5'd6, 1'b0, 32'h0000_0C0C, 1'b0);
    #1;
    chk("mid_stall", 32'(load_use_stall), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_v", 32'(ifc.ex_valid), 32'd0);
    chk("mid_rst_cnt", 32'(stall_count), 32'd0);
    chk("mid_rst_stall", 32'(load_use_stall), 32'd0);
    #1;
    reset = 1'b1;
    tick();
    chk("post_rst_v", 32'(ifc.ex_valid), 32'd1);
    chk("post_rst_rs", 32'(ifc.ex_rs_addr), 32'd5);
    chk("post_rst_d1", ifc.ex_rd_data1, 32'h0000_0C0C);
    chk("post_rst_cnt", 32'(stall_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
